// File: rtl/binary_counter.sv
// Saturating 8-bit LED up-counter with a parameterised tick prescaler.
// Define BINARY_COUNTER_WRAP_EN to roll over to 0 after MAX_COUNT instead of holding.
module binary_counter #(
   parameter int unsigned MAX_COUNT = 255,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] leds
);

   localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [7:0]       CNT_MAX  = 8'(MAX_COUNT);

   generate
      if (MAX_COUNT < 1 || MAX_COUNT > 255) begin : g_bad_max_count
         $error("binary_counter: MAX_COUNT must be in 1..255");
      end
      if (TICK_DIV < 1 || TICK_DIV > (1 << 24)) begin : g_bad_tick_div
         $error("binary_counter: TICK_DIV must be in 1..2^24");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic [7:0]       cnt;
   logic [7:0]       cnt_next;
   logic             tick;

   assign tick = (TICK_DIV == 1) ? 1'b1 : (div_cnt == DIV_LAST);

   always_comb begin
      div_next = div_cnt + DIV_W'(1);
      if (tick) begin
         div_next = '0;
      end
   end

   always_comb begin
      cnt_next = cnt;
      if (tick) begin
         if (cnt < CNT_MAX) begin
            cnt_next = cnt + 8'd1;
         end else begin
`ifdef BINARY_COUNTER_WRAP_EN
            cnt_next = '0;
`else
            cnt_next = CNT_MAX;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         cnt     <= '0;
      end else begin
         div_cnt <= div_next;
         cnt     <= cnt_next;
      end
   end

   assign leds = cnt;

endmodule

// File: tb/tb_binary_counter.sv
// Randomised reset/run bench for binary_counter across several MAX_COUNT/TICK_DIV builds.
// The reference value is derived purely from the number of edges seen since reset release.
module tb_binary_counter;

   logic       clk;
   logic       rst;
   logic [7:0] leds_a;
   logic [7:0] leds_b;
   logic [7:0] leds_c;
   logic [7:0] leds_d;

   int unsigned n_checks;
   int unsigned n_fail;
   int unsigned edges;

   binary_counter #(.MAX_COUNT(100), .TICK_DIV(1)) dut_a (.clk(clk), .rst(rst), .leds(leds_a));
   binary_counter #(.MAX_COUNT(100), .TICK_DIV(4)) dut_b (.clk(clk), .rst(rst), .leds(leds_b));
   binary_counter #(.MAX_COUNT(255), .TICK_DIV(3)) dut_c (.clk(clk), .rst(rst), .leds(leds_c));
   binary_counter #(.MAX_COUNT(1),   .TICK_DIV(2)) dut_d (.clk(clk), .rst(rst), .leds(leds_d));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model(input int unsigned e, input int unsigned mx,
                                        input int unsigned d);
      int unsigned n;
      n = e / d;
`ifdef BINARY_COUNTER_WRAP_EN
      return 8'(n % (mx + 1));
`else
      return 8'((n > mx) ? mx : n);
`endif
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: leds=%0d expected %0d", tag, edges, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_m100_d1"}, leds_a, model(edges, 100, 1));
      check({tag, "_m100_d4"}, leds_b, model(edges, 100, 4));
      check({tag, "_m255_d3"}, leds_c, model(edges, 255, 3));
      check({tag, "_m1_d2"},   leds_d, model(edges, 1, 2));
   endtask

   // One rising edge, sampled on the following falling edge.
   task automatic step(input string tag);
      @(posedge clk);
      if (rst) edges++;
      @(negedge clk);
      check_all(tag);
   endtask

   // Asynchronous reset pulse landing between edges; checked before any clock edge.
   task automatic pulse_reset(input int unsigned hold);
      #($urandom_range(1, 3));
      rst   = 1'b0;
      edges = 0;
      #1;
      check_all("rst_async");
      for (int unsigned i = 0; i < hold; i++) step("rst_hold");
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      edges    = 0;
      rst      = 1'b0;

      // Power-up: held in reset for 5 edges, then 1, 2, 3 ...
      @(negedge clk);
      check_all("powerup");
      for (int unsigned i = 0; i < 5; i++) step("powerup_hold");
      rst = 1'b1;
      for (int unsigned i = 0; i < 3; i++) step("first_counts");
      check("first_three", leds_a, 8'd3);

      // Saturation at 100 and prescaler reaching 100 at edge 400.
      while (edges < 150) step("saturate");
`ifndef BINARY_COUNTER_WRAP_EN
      check("sat_hold_d1", leds_a, 8'd100);
`endif
      while (edges < 400) step("prescale");
`ifndef BINARY_COUNTER_WRAP_EN
      check("prescale_400", leds_b, 8'd100);
`endif

      // Mid-count reset at 40, then resume.
      pulse_reset(0);
      while (edges < 40) step("to_40");
      check("mid_40", leds_a, 8'd40);
      pulse_reset(0);
      check("mid_rst_zero", leds_a, 8'd0);
      for (int unsigned i = 0; i < 2; i++) step("resume");

      // Reset while saturated, then 5000 edges (1 s at 5 kHz).
      while (edges < 120) step("to_sat");
      pulse_reset(1);
      check("sat_rst_zero", leds_a, 8'd0);
      for (int unsigned i = 0; i < 5000; i++) step("long_run");
`ifndef BINARY_COUNTER_WRAP_EN
      check("long_run_sat", leds_a, 8'd100);
`endif

      // Randomised run lengths interleaved with random reset pulses.
      for (int unsigned r = 0; r < 40; r++) begin
         int unsigned len;
         len = $urandom_range(1, 900);
         for (int unsigned i = 0; i < len; i++) step("rand_run");
         pulse_reset($urandom_range(0, 3));
      end
      for (int unsigned i = 0; i < 10; i++) step("tail");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/binary_counter.md
# binary_counter

Free-running 8-bit up-counter that drives the board LED bank directly and stops at a configurable ceiling. A parameterised prescaler sets how many clock cycles pass between increments. An asynchronous active-low reset returns the count to zero. The block sits at the top of LED demo designs, between the board clock/button pins and the `leds` pins.

## Interface
- `MAX_COUNT`, default 255: terminal count, legal range 1..255.
- `TICK_DIV`, default 1: clock cycles per increment, legal range 1..2^24.
- `clk`, input, 1 bit: sole clock, rising-edge active.
- `rst`, input, 1 bit: reset, asynchronous and active-low.
- `leds`, output, 8 bits: current count, registered, unsigned binary, bit 0 is the LSB.

## Operation
- Internal state:
  - prescaler `div_cnt`, width `$clog2(TICK_DIV)` with a minimum of 1 bit;
  - count register `cnt[7:0]`, driven directly onto `leds`.
- `tick` is asserted when `div_cnt == TICK_DIV-1`. When `TICK_DIV == 1`, `tick` is constantly 1.
- Prescaler: `div_cnt` increments every clock and wraps to 0 on `tick`.
- Count update on a rising `clk` edge with `tick` = 1:
  - `cnt < MAX_COUNT`: `cnt <= cnt + 1`.
  - `cnt == MAX_COUNT`: hold (saturate). The prescaler keeps running.
- No change to `cnt` on edges where `tick` = 0.
- `cnt` never exceeds `MAX_COUNT`. Arithmetic is 8-bit unsigned and cannot overflow, because `MAX_COUNT` ≤ 255.
- Reset:
  - `rst` = 0 clears `cnt` and `div_cnt` to 0 immediately, with no clock required.
  - Both registers hold at 0 for as long as `rst` is low.
- Reset applied mid-count or while saturated: same immediate clear. Counting restarts from 0 after release.
- Out-of-range parameters (`MAX_COUNT` of 0 or above 255, `TICK_DIV` of 0) are rejected at elaboration with an error via a generate-time check.

## Timing
- Reset value of outputs: `leds` = 8'h00.
- Reset assertion takes effect combinationally into the flops (asynchronous clear).
- Reset deassertion is used unsynchronised. The board button is assumed quasi-static relative to `clk`. Release must meet recovery time to the next edge.
- Latency with `TICK_DIV` = 1:
  - first rising edge after `rst` goes high: `leds` = 1;
  - after N edges: `leds` = min(N, `MAX_COUNT`).
- Latency with `TICK_DIV` = D: the first increment lands on the D-th rising edge after release. Thereafter there is one increment every D edges.
- Saturation: `leds` reaches `MAX_COUNT` after `MAX_COUNT`·D edges and stays there until reset.
- Reset and a tick edge coinciding: reset wins, and `leds` = 0.

## Configuration
- `BINARY_COUNTER_WRAP_EN`:
  - Defined: on a tick with `cnt == MAX_COUNT`, `cnt <= 0` (modulo `MAX_COUNT`+1 rollover), and counting continues indefinitely.
  - Undefined (default): saturate and hold at `MAX_COUNT`, as described in Operation.
- Reset behaviour and prescaler are identical in both builds.

## Test plan
All scenarios use `MAX_COUNT`=100, `TICK_DIV`=1 unless stated otherwise.
- Power-up: `rst`=0 for 5 cycles -> `leds`=0 throughout. Release -> `leds` reads 1, 2, 3 on successive edges.
- Saturation: release and run 150 edges -> `leds`=100 from edge 100 onward and never 101.
- Mid-count reset: run 40 edges (`leds`=40), pulse `rst` low between edges -> `leds`=0 before the next edge. After release, the count resumes 1, 2, ...
- Reset while saturated: hold at 100, assert `rst` -> 0 immediately. After 1 s of run at 5 kHz -> `leds`=100 again.
- Prescaler: `TICK_DIV`=4 -> `leds` becomes 1 at edge 4, 2 at edge 8, and 100 at edge 400.
- Wrap build, with `BINARY_COUNTER_WRAP_EN` defined: the edge after `leds`=100 gives `leds`=0, then 1 on the following edge.
